// File: rtl/irq_ctrl8_if.sv
// Request/acknowledge bundle between the interrupt front end (slave) and its driver/consumer (master).
interface irq_ctrl8_if;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       en;
  logic       irq_ack;
  logic       eoi;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       busy;
  logic [7:0] pending;
  logic       any_req;

  modport slave (
    input  irq_in, mask, en, irq_ack, eoi,
    output irq_valid, irq_id, busy, pending, any_req
  );

  modport master (
    output irq_in, mask, en, irq_ack, eoi,
    input  irq_valid, irq_id, busy, pending, any_req
  );
endinterface

// File: rtl/irq_ctrl8.sv
// 8-line interrupt front end: sync, pending capture, priority select (bit 7 highest), valid/ack then in-service until eoi.
// Optional macro IRQ_EDGE_EN selects rising-edge capture; default build uses level capture.
module irq_ctrl8 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  irq_ctrl8_if.slave  bus
);

  generate
    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("irq_ctrl8: SYNC_STAGES must be 1 to 3");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] s;
  logic [7:0] set_w;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [7:0] pending_q, pending_d;
  logic [2:0] hi_idx;
  logic [2:0] irq_id_q, irq_id_d;
  logic       irq_valid_q, irq_valid_d;
  logic       busy_q, busy_d;
  state_t     state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_EN
  logic [7:0] s_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_prev_q <= '0;
    else     s_prev_q <= s;
  end

  assign set_w = s & ~s_prev_q;
`else
  assign set_w = s;
`endif

  assign elig = pending_q & ~bus.mask;

  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) hi_idx = 3'(i);
    end
  end

  // Set has priority over clear so a request arriving on the ack cycle survives.
  assign pending_d = (pending_q & ~clr) | set_w;

  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    busy_d      = busy_q;
    clr         = '0;
    case (state_q)
      IDLE: begin
        if (bus.en && (elig != 8'd0)) begin
          state_d     = REQ;
          irq_valid_d = 1'b1;
          irq_id_d    = hi_idx;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          clr[irq_id_q] = 1'b1;
          irq_valid_d   = 1'b0;
          busy_d        = 1'b1;
          state_d       = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;
  assign bus.any_req   = (|elig) & bus.en;

endmodule
